dbus_wb_if: RTL
===============

Name: dbus_wb_if

Overview:
- Data-side bus bridge directly downstream of the MEM stage.
- Turns the MEM stage's single-cycle memory request (ce/we/sel/addr/data) into a Wishbone-classic bus cycle with variable latency.
- Raises a stall request to the pipeline controller while the access is outstanding, and returns read data to the MEM stage.
- Holds returned read data while the pipeline remains stalled for other reasons, so the data is not lost.

Parameters:
- STALL_IDX, 4, index of the MEM stage bit within stall_i.
- TIMEOUT, 255, maximum BUSY cycles without ack before the access is aborted (8-bit counter).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset: synchronous, active-high.
- stall_i  in  6  pipeline stall vector from ctrl.
- flush_i  in  1  pipeline flush from ctrl.
- cpu_ce_i  in  1  MEM stage chip enable (mem_ce_o).
- cpu_we_i  in  1  MEM stage write enable.
- cpu_sel_i  in  4  byte lane select; sel[3] = bits 31:24 (big-endian lanes).
- cpu_addr_i  in  32  byte address.
- cpu_data_i  in  32  store data, already lane-aligned by MEM.
- cpu_data_o  out  32  load data to MEM (mem_data_i).
- stallreq_o  out  1  stall request to ctrl.
- err_o  out  1  one-cycle pulse on timeout abort.
- bus_ack_i  in  1  Wishbone ack.
- bus_data_i  in  32  Wishbone read data.
- bus_cyc_o  out  1  Wishbone cycle.
- bus_stb_o  out  1  Wishbone strobe.
- bus_we_o  out  1  Wishbone write enable.
- bus_sel_o  out  4  Wishbone byte select.
- bus_adr_o  out  32  Wishbone address.
- bus_dat_o  out  32  Wishbone write data.

Behaviour:
- State machine: IDLE, BUSY, WAIT_STALL. All bus_* outputs, err_o, rd_buf and the timeout counter are registered.
- Reset: state=IDLE; bus_cyc/stb/we=0; bus_sel=0; bus_adr=0; bus_dat=0; rd_buf=0; cnt=0; err_o=0.
- Reset mid-access drops cyc/stb on the next edge; no ack is awaited.
- IDLE:
  - If cpu_ce_i=1 and flush_i=0: latch addr/data/we/sel onto bus_* and set cyc=stb=1 at the next edge; cnt<=0; go to BUSY.
  - stallreq_o=1 combinationally in that same cycle.
  - Otherwise stallreq_o=0 and cpu_data_o=0.
- BUSY, on bus_ack_i=1:
  - Next edge: cyc=stb=we=0, sel=0, adr=0, dat=0. If we=0, rd_buf<=bus_data_i.
  - Combinationally in the ack cycle: stallreq_o=0, cpu_data_o=bus_data_i (0 for writes).
  - Next state: WAIT_STALL if stall_i[STALL_IDX]=1, else IDLE.
- BUSY, flush_i=1 (takes priority over ack):
  - Next edge: cyc=stb=0; go to IDLE; the ack is ignored and rd_buf is unchanged.
  - stallreq_o=0.
- BUSY, no ack and no flush:
  - stallreq_o=1 and cnt increments.
  - When cnt reaches TIMEOUT: drop cyc/stb at the next edge, go to WAIT_STALL with rd_buf<=0, and pulse err_o for 1 cycle.
- WAIT_STALL:
  - stallreq_o=0 and cpu_data_o=rd_buf.
  - When stall_i[STALL_IDX]=0 or flush_i=1: go to IDLE at the next edge.
  - A new cpu_ce_i is not accepted in WAIT_STALL; it is accepted in the cycle after returning to IDLE.
- Latency: request seen in cycle 0, bus_stb valid in cycle 1, earliest ack in cycle 1, giving a minimum of 1 stall cycle per access.
- Bus outputs are stable throughout BUSY; bus_stb_o always equals bus_cyc_o.
- bus_ack_i outside BUSY is ignored.
- No pipelined or back-to-back bus cycles: cyc returns low for at least 1 cycle between accesses.

Decomposition:
- Shared package/define file holds:
  - state encodings WB_IDLE=2'b00, WB_BUSY=2'b01, WB_WAIT_STALL=2'b11;
  - stall vector bit indices (PC, IF, ID, EX, MEM=4, WB).
- Existing RstEnable/ChipEnable/WriteEnable/ZeroWord defines are reused.
- Single module; no sub-module. The instruction-side bridge is a separate instance with STALL_IDX=1.

Test Plan:
- Load with 2-cycle ack latency: ce=1, we=0, addr=0x80, sel=4'b1111; ack in cycle 2 with bus_data=0xDEADBEEF -> stallreq=1 in cycles 0–1, 0 in cycle 2; cpu_data_o=0xDEADBEEF in cycle 2; cyc=0 in cycle 3.
- Store: ce=1, we=1, addr=0x102, sel=4'b0011, data=0x0000ABCD, ack in cycle 1 -> bus_we=1, adr=0x102, sel=0011, dat=0x0000ABCD in cycle 1; 1 stall cycle.
- Ack while stall_i[4]=1 held for 3 more cycles, bus_data=0x12345678 -> state WAIT_STALL; cpu_data_o=0x12345678 for all 3 cycles, stallreq=0; returns to IDLE when stall_i[4]=0.
- flush_i=1 in BUSY coincident with ack -> cyc=0 at the next edge; state IDLE; rd_buf unchanged; no WAIT_STALL.
- No ack for TIMEOUT=255 cycles -> stallreq high for 256 cycles; err_o pulses once; cpu_data_o=0; cyc drops.
- rst asserted during BUSY -> all outputs 0 at the next edge; a new request right after reset completes normally.

Source files
------------

// File: rtl/dbus_wb_if_pkg.sv
// rtl/dbus_wb_if_pkg.sv - shared encodings and constants for the bus bridges
package dbus_wb_if_pkg;

  typedef enum logic [1:0] {
    WB_IDLE       = 2'b00,
    WB_BUSY       = 2'b01,
    WB_WAIT_STALL = 2'b11
  } wb_state_t;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic        RST_ENABLE   = 1'b1;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

endpackage

// File: rtl/dbus_wb_if_if.sv
// rtl/dbus_wb_if_if.sv - Wishbone-classic bus signals between bridge and bus
interface dbus_wb_if_if;
  logic        bus_ack_i;
  logic [31:0] bus_data_i;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_adr_o;
  logic [31:0] bus_dat_o;

  modport master (
    input  bus_ack_i, bus_data_i,
    output bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o
  );

  modport slave (
    output bus_ack_i, bus_data_i,
    input  bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o
  );
endinterface

// File: rtl/dbus_wb_if.sv
// rtl/dbus_wb_if.sv - MEM-stage to Wishbone-classic bridge with stall and read-data hold
module dbus_wb_if
  import dbus_wb_if_pkg::*;
#(
  parameter int STALL_IDX = STALL_MEM,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        err_o,
  dbus_wb_if_if.master bus
);

  // Abort fires in the BUSY cycle whose count reaches TIMEOUT after incrementing,
  // so at most TIMEOUT cycles are spent in BUSY without an ack.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  wb_state_t   state;
  logic [7:0]  cnt;
  logic [31:0] rd_buf;
  logic        hold_stall;

  assign hold_stall = stall_i[STALL_IDX];

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state         <= WB_IDLE;
      bus.bus_cyc_o <= 1'b0;
      bus.bus_stb_o <= 1'b0;
      bus.bus_we_o  <= 1'b0;
      bus.bus_sel_o <= 4'b0000;
      bus.bus_adr_o <= ZERO_WORD;
      bus.bus_dat_o <= ZERO_WORD;
      rd_buf        <= ZERO_WORD;
      cnt           <= 8'd0;
      err_o         <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (cpu_ce_i == CHIP_ENABLE && !flush_i) begin
            bus.bus_cyc_o <= 1'b1;
            bus.bus_stb_o <= 1'b1;
            bus.bus_we_o  <= cpu_we_i;
            bus.bus_sel_o <= cpu_sel_i;
            bus.bus_adr_o <= cpu_addr_i;
            bus.bus_dat_o <= cpu_data_i;
            cnt           <= 8'd0;
            state         <= WB_BUSY;
          end
        end
        WB_BUSY: begin
          if (flush_i || bus.bus_ack_i || cnt == CNT_LAST) begin
            bus.bus_cyc_o <= 1'b0;
            bus.bus_stb_o <= 1'b0;
            bus.bus_we_o  <= 1'b0;
            bus.bus_sel_o <= 4'b0000;
            bus.bus_adr_o <= ZERO_WORD;
            bus.bus_dat_o <= ZERO_WORD;
          end
          if (flush_i) begin
            state <= WB_IDLE;
          end else if (bus.bus_ack_i) begin
            if (bus.bus_we_o != WRITE_ENABLE) rd_buf <= bus.bus_data_i;
            state <= hold_stall ? WB_WAIT_STALL : WB_IDLE;
          end else if (cnt == CNT_LAST) begin
            rd_buf <= ZERO_WORD;
            err_o  <= 1'b1;
            state  <= WB_WAIT_STALL;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WB_WAIT_STALL: begin
          if (!hold_stall || flush_i) state <= WB_IDLE;
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = ZERO_WORD;
    case (state)
      WB_IDLE: begin
        stallreq_o = (cpu_ce_i == CHIP_ENABLE) && !flush_i;
      end
      WB_BUSY: begin
        if (flush_i) begin
          stallreq_o = 1'b0;
        end else if (bus.bus_ack_i) begin
          cpu_data_o = (bus.bus_we_o == WRITE_ENABLE) ? ZERO_WORD : bus.bus_data_i;
        end else begin
          stallreq_o = 1'b1;
        end
      end
      WB_WAIT_STALL: begin
        cpu_data_o = rd_buf;
      end
      default: begin
        stallreq_o = 1'b0;
      end
    endcase
  end

endmodule
